// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Resolves load-use hazards, taken branches in EX and multi-cycle data-memory
// accesses. A wait-state FSM with a watchdog halts the pipe on a stuck memory,
// and a saturating counter tracks the cycles in which the PC is held.
module pipe_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs_addr,
    input  logic [4:0]       id_rt_addr,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_memrd,
    input  logic             ex_regwr,
    input  logic [4:0]       ex_wr_addr,
    input  logic             branch_taken_ex,
    input  logic             mem_req,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_t;

    localparam logic [8:0] TIMEOUT = 9'(MEM_TIMEOUT);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [8:0] wait_next;
    logic       mem_stall;
    logic       load_use;

    // Hazard detection: memory stall and load-use match against the EX load.
    always_comb begin
        mem_stall = ((state == RUN) && mem_req && !dmem_ready) ||
                    ((state == MEM_WAIT) && !dmem_ready);
        load_use  = (state == RUN) && ex_memrd && ex_regwr && (ex_wr_addr != 5'd0) &&
                    ((id_uses_rs && (id_rs_addr == ex_wr_addr)) ||
                     (id_uses_rt && (id_rt_addr == ex_wr_addr)));
        wait_next = {1'b0, wait_cnt} + 9'd1;
    end

    // Stage controls, highest priority first: halt, memory stall, branch, load-use.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (state == HALT) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (branch_taken_ex) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Wait-state FSM with watchdog; the counter holds the number of wait cycles
    // seen so far, so the timeout is judged on the count this cycle would reach.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (mem_req && !dmem_ready) begin
                        wait_cnt <= 8'd1;
                        if (TIMEOUT <= 9'd1) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end else begin
                            state <= MEM_WAIT;
                        end
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_next[7:0];
                        if (wait_next >= TIMEOUT) begin
                            state   <= HALT;
                            mem_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC does not advance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (!pc_en && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It generates the load enables and bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It covers load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. It includes a wait-state FSM with a watchdog and a stall-cycle performance counter.

Parameters:
MEM_TIMEOUT, 15, max consecutive MEM_WAIT cycles before error halt (1..255)
CNT_W, 16, width of stall_cnt

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
id_rs_addr  in  5  rs of instruction in ID
id_rt_addr  in  5  rt of instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memrd  in  1  EX instruction is a load
ex_regwr  in  1  EX instruction writes a register
ex_wr_addr  in  5  EX destination register
branch_taken_ex  in  1  branch/jump in EX is taken
mem_req  in  1  MEM-stage instruction accesses data memory
dmem_ready  in  1  data memory completes access this cycle
pc_en  out  1  PC load enable
ifid_en  out  1  IF/ID load enable
ifid_flush  out  1  IF/ID loads NOP
idex_en  out  1  ID/EX load enable
idex_flush  out  1  ID/EX loads bubble (RegWr=0, MemRd=0, MemWr=0)
exmem_en  out  1  EX/MEM load enable
memwb_en  out  1  MEM/WB load enable
memwb_bubble  out  1  MEM/WB loads RegWr=0
mem_err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset (rst=0 at posedge): state=RUN, wait counter=0, mem_err=0, stall_cnt=0.
- Outputs are combinational from state plus inputs. Default (no event): all *_en=1, all flush/bubble=0.
- Memory stall condition: (state==RUN && mem_req && !dmem_ready) || (state==MEM_WAIT && !dmem_ready).
  - When asserted: pc_en=ifid_en=idex_en=exmem_en=0, memwb_en=1, memwb_bubble=1. Flushes are suppressed.
- RUN -> MEM_WAIT when mem_req && !dmem_ready. The wait counter loads 1.
- MEM_WAIT -> RUN on dmem_ready. In that same cycle all enables=1 and memwb_bubble=0, so the load data is captured. The wait counter clears.
- MEM_WAIT with !dmem_ready increments the wait counter. When the counter reaches MEM_TIMEOUT with dmem_ready still 0: next state=HALT, mem_err<=1.
- mem_req with dmem_ready=1 in RUN is a zero-wait access: no stall, state stays RUN.
- HALT: all *_en=0, memwb_bubble=1, flushes=0. Exited only by reset. mem_err stays 1 until reset.
- Branch flush (no memory stall, not HALT): when branch_taken_ex=1, ifid_flush=1 and idex_flush=1, all enables=1.
- Branch during memory stall: no flush while stalled. EX is frozen, so branch_taken_ex is re-presented and the flush takes effect in the release cycle.
- Load-use (RUN, no memory stall, no taken branch):
  - Condition: ex_memrd && ex_regwr && ex_wr_addr!=0 && ((id_uses_rs && id_rs_addr==ex_wr_addr) || (id_uses_rt && id_rt_addr==ex_wr_addr)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1, other enables=1. Lasts one cycle; the bubble removes the condition.
- Priority: HALT > memory stall > branch flush > load-use. A taken branch and a load-use in the same cycle resolve to a branch flush with pc_en=1.
- Register $0 never triggers load-use.
- stall_cnt increments on each cycle with pc_en=0, including HALT. It saturates at all-ones.
- Reset mid-MEM_WAIT: returns to RUN and clears counters. No residual stall in the cycle after reset.

Test Plan:
- Load-use: ex_memrd=1, ex_regwr=1, ex_wr_addr=8, id_rs_addr=8, id_uses_rs=1 -> one cycle pc_en=0, ifid_en=0, idex_flush=1; next cycle (inputs cleared) all enables=1; stall_cnt=1.
- Same as above with ex_wr_addr=0, or with id_uses_rs=0 -> no stall.
- mem_req=1, dmem_ready low for 3 cycles then high -> 3 cycles of upstream en=0 and memwb_bubble=1, release on the 4th cycle with memwb_en=1 and bubble=0; stall_cnt=3.
- branch_taken_ex=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1; stall_cnt unchanged.
- Branch during a 2-cycle memory wait -> flushes 0 during the wait, ifid_flush=idex_flush=1 in the release cycle.
- dmem_ready held 0 with MEM_TIMEOUT=15 -> HALT entered after 15 wait cycles, mem_err=1, all en=0 until rst=0; after reset, state=RUN and mem_err=0.
